instr_encoder: RTL and testbench

Encodes RV32I micro-op descriptors (ALU-imm, ALU-reg, SW, LW, branch) into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. It is the encode-side counterpart of the pipeline's control decode: the boot loader and test harness use it to fill imem before the core is released from reset. Input and output use valid/ready handshakes, with a small FIFO between encode and memory write.

---
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I micro-op encoder: turns descriptors into instruction words and streams
// them through a small FIFO into imem at consecutive word addresses.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  input  logic              err_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]       FULL_OCC = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  logic [31:0] word;
  logic        illegal;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (in_cls)
      3'd0: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      3'd1: word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd2: word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      3'd3: word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      3'd4: begin
        word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], 7'b1100011};
        // funct3 010/011 are not branch conditions; targets must be halfword aligned
        illegal = (in_funct3[2:1] == 2'b01) || in_imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  logic          accept, push, pop;
  logic [31:0]   fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ, occ_next;

  assign accept    = in_valid && in_ready;
  assign push      = accept && !illegal;
  assign mem_valid = (occ != '0);
  assign pop       = mem_valid && mem_ready;
  assign mem_wdata = mem_valid ? fifo[rd_ptr] : '0;

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= word;
  end

  // in_ready is registered from next occupancy, so a full FIFO never pushes
  // even when a pop happens in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      in_ready <= 1'b0;
      mem_addr <= BASE;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      occ      <= occ_next;
      in_ready <= (occ_next != FULL_OCC);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_addr <= mem_addr + 1'b1;
        if (count != '1) count <= count + 1'b1;
      end
      if (accept && illegal) err <= 1'b1;
      else if (err_clr)      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a queue-based behavioural model,
// plus directed sequences with hand-computed instruction words.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int BASE  = 15;
  localparam int CMAX  = 31;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } desc_t;

  logic          clk = 0, rst = 1;
  logic          in_valid = 0, in_ready;
  logic [2:0]    in_cls = 0, in_funct3 = 0;
  logic          in_alt = 0;
  logic [4:0]    in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [12:0]   in_imm = 0;
  logic          mem_valid, mem_ready = 0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          err, err_clr = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: places each field by arithmetic on its bit offset.
  function automatic logic [31:0] enc(input desc_t d);
    int unsigned im = 32'(d.imm);
    logic [31:0] w = 0;
    case (d.cls)
      0: begin
        w = 32'h13 + (32'(d.rd) << 7) + (32'(d.f3) << 12) + (32'(d.rs1) << 15);
        if (d.f3 == 1 || d.f3 == 5) w += ((im % 32) << 20) + (32'(d.alt) << 30);
        else                        w += (im % 4096) << 20;
      end
      1: w = 32'h33 + (32'(d.rd) << 7) + (32'(d.f3) << 12) + (32'(d.rs1) << 15)
             + (32'(d.rs2) << 20) + (32'(d.alt) << 30);
      2: w = 32'h23 + ((im % 32) << 7) + (2 << 12) + (32'(d.rs1) << 15)
             + (32'(d.rs2) << 20) + (((im / 32) % 128) << 25);
      3: w = 32'h03 + (32'(d.rd) << 7) + (2 << 12) + (32'(d.rs1) << 15) + ((im % 4096) << 20);
      4: w = 32'h63 + (((im >> 11) % 2) << 7) + (((im >> 1) % 16) << 8) + (32'(d.f3) << 12)
             + (32'(d.rs1) << 15) + (32'(d.rs2) << 20) + (((im >> 5) % 64) << 25)
             + (((im >> 12) % 2) << 31);
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit bad(input desc_t d);
    return d.cls >= 5 || (d.cls == 4 && (d.f3 == 2 || d.f3 == 3 || d.imm[0]));
  endfunction

  function automatic desc_t mk(input int c, input int f, input int a, input int rd,
                               input int r1, input int r2, input int imm);
    desc_t d;
    d.cls = 3'(c); d.f3 = 3'(f); d.alt = 1'(a);
    d.rd = 5'(rd); d.rs1 = 5'(r1); d.rs2 = 5'(r2); d.imm = 13'(imm);
    return d;
  endfunction

  function automatic desc_t rnd_desc();
    desc_t d;
    d = desc_t'({$urandom, $urandom});
    if ($urandom_range(0, 99) < 8) d.cls = 3'($urandom_range(5, 7));
    else d.cls = 3'($urandom_range(0, 4));
    if (d.cls == 4 && $urandom_range(0, 9) > 1) begin
      d.imm[0] = 1'b0;
      if (d.f3 == 2 || d.f3 == 3) d.f3 = 3'b000;
    end
    return d;
  endfunction

  // ---- model state and write log ----
  logic [31:0] mq[$];
  logic [31:0] wdat[$];
  int          wadr[$], wcyc[$];
  int          m_addr = BASE, m_count = 0, cyc = 0;
  bit          m_err = 0, m_rdy = 0;
  int          mr_mode = 0;

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       mem_ready = 1'b0;
      1:       mem_ready = 1'b1;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare DUT outputs to the model every cycle, then advance the model
  // across the coming rising edge (inputs are stable from here to that edge).
  always @(negedge clk) begin
    desc_t d;
    bit    acc, pp;
    cyc++;
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_mem_addr", 32'(mem_addr), BASE);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_err", 32'(err), 0);
      mq.delete(); m_addr = BASE; m_count = 0; m_err = 0; m_rdy = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("mem_valid", 32'(mem_valid), 32'(mq.size() != 0));
      chk("mem_wdata", mem_wdata, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("count", 32'(count), 32'(m_count));
      chk("err", 32'(err), 32'(m_err));
      d = {in_cls, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm};
      acc = in_valid && m_rdy;
      pp  = (mq.size() != 0) && mem_ready;
      if (pp) begin
        wdat.push_back(mq.pop_front());
        wadr.push_back(m_addr);
        wcyc.push_back(cyc);
        m_addr = (m_addr + 1) % (1 << AW);
        if (m_count < CMAX) m_count++;
      end
      if (acc && bad(d))  m_err = 1;
      else if (err_clr)   m_err = 0;
      if (acc && !bad(d)) mq.push_back(enc(d));
      m_rdy = (mq.size() != DEPTH);
    end
  end

  task automatic send(input desc_t d);
    bit ok = 0, rdy;
    in_cls = d.cls; in_funct3 = d.f3; in_alt = d.alt;
    in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm;
    in_valid = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    in_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // model pins against hand-encoded words
    chk("model_addi", enc(mk(0, 0, 0, 1, 0, 0, 5)), 32'h00500093);
    chk("model_srai", enc(mk(0, 5, 1, 2, 1, 0, 3)), 32'h4030D113);
    chk("model_sub",  enc(mk(1, 0, 1, 3, 1, 2, 0)), 32'h402081B3);
    chk("model_beq",  enc(mk(4, 0, 0, 0, 1, 2, -8)), 32'hFE208CE3);

    cycles(3);
    rst = 0;

    // ADDI / SRAI / SUB streamed at full rate
    mr_mode = 1;
    cycles(1);
    send(mk(0, 0, 0, 1, 0, 0, 5));
    send(mk(0, 5, 1, 2, 1, 0, 3));
    send(mk(1, 0, 1, 3, 1, 2, 0));
    cycles(4);
    chk("n_writes_a", wdat.size(), 3);
    if (wdat.size() >= 3) begin
      chk("w0", wdat[0], 32'h00500093);
      chk("w1", wdat[1], 32'h4030D113);
      chk("w2", wdat[2], 32'h402081B3);
      chk("a0", wadr[0], 15);
      chk("a1_wrap", wadr[1], 0);
      chk("a2", wadr[2], 1);
      chk("gap01", wcyc[1] - wcyc[0], 1);
      chk("gap12", wcyc[2] - wcyc[1], 1);
    end
    @(negedge clk) chk("count3", 32'(count), 3);
    cycles(1);

    // SW / LW / BEQ
    send(mk(2, 0, 0, 9, 1, 2, 8));
    send(mk(3, 0, 0, 5, 1, 0, -4));
    send(mk(4, 0, 0, 0, 1, 2, -8));
    cycles(4);
    chk("n_writes_b", wdat.size(), 6);
    if (wdat.size() >= 6) begin
      chk("w_sw", wdat[3], 32'h0020A423);
      chk("w_lw", wdat[4], 32'hFFC0A283);
      chk("w_beq", wdat[5], 32'hFE208CE3);
    end

    // back-pressure: FIFO fills after 4 accepts
    n0 = wdat.size();
    mr_mode = 0;
    cycles(2);
    fork
      for (int i = 0; i < 5; i++) send(mk(1, i, 0, i + 1, i, i + 2, 0));
      begin
        repeat (10) @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_mem_valid", 32'(mem_valid), 1);
        chk("full_no_write", wdat.size(), n0);
        mr_mode = 1;
      end
    join
    cycles(6);
    chk("n_writes_c", wdat.size(), n0 + 5);
    if (wdat.size() >= n0 + 5)
      for (int i = 0; i < 3; i++) chk("bp_gap", wcyc[n0 + i + 1] - wcyc[n0 + i], 1);

    // illegal descriptors
    n0 = wdat.size();
    send(mk(4, 0, 0, 0, 1, 2, 3));
    send(mk(6, 0, 0, 1, 1, 1, 0));
    cycles(2);
    @(negedge clk);
    chk("ill_err", 32'(err), 1);
    chk("ill_no_write", wdat.size(), n0);
    chk("ill_valid", 32'(mem_valid), 0);
    @(posedge clk) #1 err_clr = 1;
    @(posedge clk) #1 err_clr = 0;
    @(negedge clk) chk("err_cleared", 32'(err), 0);
    @(posedge clk) #1 err_clr = 1;
    send(mk(7, 0, 0, 0, 0, 0, 0));
    err_clr = 0;
    @(negedge clk) chk("set_wins", 32'(err), 1);
    @(posedge clk) #1 err_clr = 1;
    @(posedge clk) #1 err_clr = 0;

    // reset with words queued
    mr_mode = 0;
    cycles(2);
    for (int i = 0; i < 3; i++) send(mk(0, 0, 0, i + 1, 0, 0, i + 7));
    n0 = wdat.size();
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(mem_valid), 0);
    chk("mid_rst_addr", 32'(mem_addr), BASE);
    chk("mid_rst_count", 32'(count), 0);
    cycles(2);
    rst = 0;
    mr_mode = 1;
    cycles(8);
    chk("rst_discard", wdat.size(), n0);

    // randomized traffic with random back-pressure and err_clr
    mr_mode = 2;
    for (int i = 0; i < 400; i++) begin
      err_clr = ($urandom_range(0, 9) == 0);
      send(rnd_desc());
      err_clr = 0;
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    mr_mode = 1;
    for (int i = 0; i < 200 && mq.size() != 0; i++) @(negedge clk);
    chk("drain", mq.size(), 0);
    @(negedge clk) chk("count_sat", 32'(count), CMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
